// File: rtl/dmni_brlite_mon_writer_if.sv
// Monitor-sample, pointer-config and memory-write signals of the
// BrLite monitor writer; slave is the writer, master drives it.
interface dmni_brlite_mon_writer_if #(
  parameter int NSVC = 2
);
  localparam int SW = (NSVC > 1) ? $clog2(NSVC) : 1;

  logic          mon_valid_i;
  logic          mon_ready_o;
  logic [SW-1:0] mon_svc_i;
  logic [15:0]   mon_producer_i;
  logic [31:0]   mon_payload_i;
  logic          cfg_we_i;
  logic [SW-1:0] cfg_svc_i;
  logic [31:0]   cfg_ptr_i;
  logic          clear_i;
  logic          mem_req_o;
  logic          mem_gnt_i;
  logic [31:0]   mem_addr_o;
  logic [31:0]   mem_data_o;
  logic [15:0]   drop_cnt_o;
  logic          busy_o;

  modport slave (
    input  mon_valid_i, mon_svc_i,
    input  mon_producer_i, mon_payload_i,
    input  cfg_we_i, cfg_svc_i, cfg_ptr_i,
    input  clear_i, mem_gnt_i,
    output mon_ready_o, mem_req_o,
    output mem_addr_o, mem_data_o,
    output drop_cnt_o, busy_o
  );

  modport master (
    output mon_valid_i, mon_svc_i,
    output mon_producer_i, mon_payload_i,
    output cfg_we_i, cfg_svc_i, cfg_ptr_i,
    output clear_i, mem_gnt_i,
    input  mon_ready_o, mem_req_o,
    input  mem_addr_o, mem_data_o,
    input  drop_cnt_o, busy_o
  );
endinterface

// File: rtl/dmni_brlite_mon_writer.sv
// BrLite monitor-sample writer: buffers samples, writes per-service tables.
// Optional DMNI_MON_COALESCE_EN merges samples of the same (svc, producer).
module dmni_brlite_mon_writer #(
  parameter int NSVC       = 2,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk_i,
  input logic rst_i,
  dmni_brlite_mon_writer_if.slave bus
);

  localparam int SW = (NSVC > 1) ? $clog2(NSVC) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t state_q, state_d;

  logic [31:0]   ptr_q  [NSVC];
  logic [SW-1:0] svc_q  [FIFO_DEPTH];
  logic [15:0]   prod_q [FIFO_DEPTH];
  logic [31:0]   pay_q  [FIFO_DEPTH];

  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic [31:0]   addr_q, data_q;
  logic [15:0]   drop_q, drop_d;

  logic          empty, full;
  logic          svc_ok;
  logic          accept, push, upd, bad;
  logic          pop, load, pop_drop;
  logic [31:0]   h_ptr;
  logic          hit;
  logic [AW-1:0] hit_idx;
  logic [1:0]    inc;
  logic [16:0]   sum;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign svc_ok = (32'(bus.mon_svc_i) < NSVC);

  assign bus.mon_ready_o = !rst_i && (!full || hit);

  assign accept = bus.mon_valid_i && bus.mon_ready_o;
  assign push   = accept && !bus.clear_i && svc_ok && !hit;
  assign upd    = accept && !bus.clear_i && hit;
  assign bad    = accept && !bus.clear_i && !svc_ok;

  always_comb begin
    h_ptr = '0;
    for (int i = 0; i < NSVC; i++) begin
      if (svc_q[rd_q] == SW'(i)) begin
        h_ptr = ptr_q[i];
      end
    end
  end

`ifdef DMNI_MON_COALESCE_EN
  logic [AW-1:0] off;

  // The head entry leaving this cycle is no longer a merge target
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    off     = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = AW'(i) - rd_q;
      if (!hit && ({1'b0, off} < cnt_q) &&
          !(pop && off == '0) &&
          svc_q[i] == bus.mon_svc_i &&
          prod_q[i] == bus.mon_producer_i) begin
        hit     = 1'b1;
        hit_idx = AW'(i);
      end
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_idx = '0;
`endif

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load     = 1'b0;
    pop_drop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty && !bus.clear_i) pop = 1'b1;
      end
      REQ: begin
        if (bus.mem_gnt_i) begin
          state_d = IDLE;
          if (!empty && !bus.clear_i) pop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      if (h_ptr == '0) begin
        pop_drop = 1'b1;
        state_d  = IDLE;
      end else begin
        load    = 1'b1;
        state_d = REQ;
      end
    end
  end

  assign inc    = 2'(bad) + 2'(pop_drop);
  assign sum    = 17'(drop_q) + 17'(inc);
  assign drop_d = sum[16] ? 16'hFFFF : sum[15:0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rd_q    <= '0;
      wr_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      drop_q  <= '0;
      for (int i = 0; i < NSVC; i++) begin
        ptr_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NSVC; i++) begin
        if (bus.cfg_we_i && bus.cfg_svc_i == SW'(i)) begin
          ptr_q[i] <= bus.cfg_ptr_i;
        end
      end
      if (bus.clear_i) begin
        rd_q   <= '0;
        wr_q   <= '0;
        cnt_q  <= '0;
        drop_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
        cnt_q  <= cnt_q + (AW+1)'(push)
                        - (AW+1)'(pop);
        drop_q <= drop_d;
      end
      if (load) begin
        addr_q <= h_ptr +
                  {14'd0, prod_q[rd_q], 2'b00};
        data_q <= pay_q[rd_q];
      end
    end
  end

  // Entry storage needs no reset; occupancy is tracked by cnt_q
  always_ff @(posedge clk_i) begin
    if (push) begin
      svc_q[wr_q]  <= bus.mon_svc_i;
      prod_q[wr_q] <= bus.mon_producer_i;
      pay_q[wr_q]  <= bus.mon_payload_i;
    end
    if (upd) begin
      pay_q[hit_idx] <= bus.mon_payload_i;
    end
  end

  assign bus.mem_req_o  = (state_q == REQ);
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = data_q;
  assign bus.drop_cnt_o = drop_q;
  assign bus.busy_o     = !empty || (state_q == REQ);

endmodule

// File: tb/tb_dmni_brlite_mon_writer.sv
// Bench for dmni_brlite_mon_writer: directed steps plus a random phase
// against a queue-based model of expected table writes and drops.
module tb_dmni_brlite_mon_writer;

  localparam int NSVC  = 3;
  localparam int DEPTH = 4;

  typedef struct {
    logic [1:0]  svc;
    logic [15:0] prod;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dmni_brlite_mon_writer_if #(.NSVC(NSVC)) bus ();

  dmni_brlite_mon_writer #(
    .NSVC(NSVC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  wr_t         exp_q[$];
  int          wr_cyc[$];
  logic [31:0] ptr_m [NSVC];
  int          drop_m = 0;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          nwr    = 0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // Reference model: writes observed on the bus must come out in order
  always @(negedge clk) begin
    wr_t         e;
    int          st;
    bit          hit;
    logic [1:0]  s;
    logic [15:0] p;
    logic [31:0] d;
    if (!rst) begin
      st = bus.mem_req_o ? (bus.mem_gnt_i ? 2 : 1) : 1;
      if (bus.mem_req_o && bus.mem_gnt_i) begin
        nwr++;
        wr_cyc.push_back(cyc);
        chk("wr_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("wr_addr", bus.mem_addr_o, e.addr);
          chk("wr_data", bus.mem_data_o, e.data);
        end
        st--;
      end
      if (bus.mon_valid_i && bus.mon_ready_o &&
          !bus.clear_i) begin
        s   = bus.mon_svc_i;
        p   = bus.mon_producer_i;
        d   = bus.mon_payload_i;
        hit = 1'b0;
        if (int'(s) >= NSVC) begin
          drop_m++;
        end else begin
`ifdef DMNI_MON_COALESCE_EN
          for (int i = st; i < exp_q.size(); i++) begin
            if (!hit && exp_q[i].svc == s &&
                exp_q[i].prod == p) begin
              exp_q[i].data = d;
              hit = 1'b1;
            end
          end
`endif
          if (!hit) begin
            if (ptr_m[s] == 32'd0) drop_m++;
            else exp_q.push_back('{s, p,
                   ptr_m[s] + {14'd0, p, 2'b00}, d});
          end
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(int s, logic [31:0] p);
    bus.cfg_we_i  = 1'b1;
    bus.cfg_svc_i = 2'(s);
    bus.cfg_ptr_i = p;
    step();
    bus.cfg_we_i  = 1'b0;
    ptr_m[s]      = p;
  endtask

  task automatic send(int s, int p, logic [31:0] d,
                      int maxw, bit exp_ok);
    int w;
    bit ok;
    w = 0;
    bus.mon_valid_i    = 1'b1;
    bus.mon_svc_i      = 2'(s);
    bus.mon_producer_i = 16'(p);
    bus.mon_payload_i  = d;
    while (!bus.mon_ready_o && w < maxw) begin
      step();
      w++;
    end
    ok = bus.mon_ready_o;
    chk("accept", 32'(ok), 32'(exp_ok));
    if (ok) step();
    bus.mon_valid_i = 1'b0;
  endtask

  task automatic wait_idle(int maxc);
    int n;
    n = 0;
    while (bus.busy_o && n < maxc) begin
      step();
      n++;
    end
    chk("idle", 32'(bus.busy_o), 0);
  endtask

  initial begin
    int  n0;
    int  sz;
    bit  coal;
    int  seq;
`ifdef DMNI_MON_COALESCE_EN
    coal = 1'b1;
`else
    coal = 1'b0;
`endif
    for (int i = 0; i < NSVC; i++) ptr_m[i] = '0;
    bus.mon_valid_i    = 1'b0;
    bus.mon_svc_i      = '0;
    bus.mon_producer_i = '0;
    bus.mon_payload_i  = '0;
    bus.cfg_we_i       = 1'b0;
    bus.cfg_svc_i      = '0;
    bus.cfg_ptr_i      = '0;
    bus.clear_i        = 1'b0;
    bus.mem_gnt_i      = 1'b1;

    step();
    step();
    chk("rst_ready", 32'(bus.mon_ready_o), 0);
    chk("rst_req", 32'(bus.mem_req_o), 0);
    chk("rst_addr", bus.mem_addr_o, 0);
    chk("rst_data", bus.mem_data_o, 0);
    chk("rst_drop", 32'(bus.drop_cnt_o), 0);
    chk("rst_busy", 32'(bus.busy_o), 0);
    rst = 1'b0;
    step();
    chk("ready_empty", 32'(bus.mon_ready_o), 1);

    // basic write and latency
    cfg(1, 32'h1000);
    n0 = nwr;
    send(1, 3, 32'hCAFE, 10, 1'b1);
    chk("lat_n1_req", 32'(bus.mem_req_o), 0);
    step();
    chk("lat_n2_req", 32'(bus.mem_req_o), 1);
    chk("lat_addr", bus.mem_addr_o, 32'h100C);
    chk("lat_data", bus.mem_data_o, 32'hCAFE);
    step();
    chk("lat_n3_req", 32'(bus.mem_req_o), 0);
    chk("lat_nwr", 32'(nwr - n0), 1);

    // disabled service and invalid service
    n0 = nwr;
    send(0, 7, 32'h1234, 10, 1'b1);
    wait_idle(20);
    step();
    chk("dis_nowr", 32'(nwr - n0), 0);
    chk("dis_drop", 32'(bus.drop_cnt_o), 32'(drop_m));
    send(3, 1, 32'h1, 10, 1'b1);
    chk("bad_drop", 32'(bus.drop_cnt_o), 32'(drop_m));
    chk("bad_busy", 32'(bus.busy_o), 0);

    // address wrap
    cfg(2, 32'hFFFF_FFFC);
    send(2, 1, 32'hBEEF, 10, 1'b1);
    step();
    chk("wrap_req", 32'(bus.mem_req_o), 1);
    chk("wrap_addr", bus.mem_addr_o, 32'h0);
    wait_idle(20);

    // backpressure then back-to-back drain
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < 5; i++)
      send(1, 10 + i, 32'h100 + i, 10, 1'b1);
    chk("full_ready", 32'(bus.mon_ready_o), 0);
    chk("full_busy", 32'(bus.busy_o), 1);
    chk("full_req", 32'(bus.mem_req_o), 1);
    chk("full_addr", bus.mem_addr_o, 32'h1028);
    n0 = nwr;
    bus.mem_gnt_i = 1'b1;
    wait_idle(20);
    sz = wr_cyc.size();
    chk("b2b_nwr", 32'(nwr - n0), 5);
    chk("b2b_span",
        32'(wr_cyc[sz-1] - wr_cyc[sz-5]), 4);
    step();
    chk("b2b_req_low", 32'(bus.mem_req_o), 0);

    // matching sample against full buffer
    bus.mem_gnt_i = 1'b0;
    n0 = nwr;
    for (int i = 0; i < 5; i++)
      send(1, 20 + i, 32'h200 + i, 10, 1'b1);
    send(1, 23, 32'h55, 3, coal);
    bus.mem_gnt_i = 1'b1;
    wait_idle(20);
    chk("coal_nwr", 32'(nwr - n0), 5);

    // clear while a write is pending
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < 4; i++)
      send(1, 30 + i, 32'h300 + i, 10, 1'b1);
    n0 = nwr;
    bus.clear_i        = 1'b1;
    bus.mon_valid_i    = 1'b1;
    bus.mon_svc_i      = 2'd1;
    bus.mon_producer_i = 16'd40;
    bus.mon_payload_i  = 32'h400;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    drop_m = 0;
    step();
    bus.clear_i     = 1'b0;
    bus.mon_valid_i = 1'b0;
    chk("clr_req", 32'(bus.mem_req_o), 1);
    step();
    bus.mem_gnt_i = 1'b1;
    wait_idle(20);
    step();
    chk("clr_nwr", 32'(nwr - n0), 1);
    chk("clr_drop", 32'(bus.drop_cnt_o), 0);
    chk("clr_left", 32'(exp_q.size()), 0);

    // pointer update in the pop cycle
    send(1, 5, 32'hA5, 10, 1'b1);
    cfg(1, 32'h2000);
    chk("cfg_old_addr", bus.mem_addr_o, 32'h1014);
    wait_idle(20);
    send(1, 5, 32'h5A, 10, 1'b1);
    step();
    chk("cfg_new_addr", bus.mem_addr_o, 32'h2014);
    wait_idle(20);

    // random traffic
    cfg(0, ($urandom_range(0, 2) == 0) ? 32'h0 : $urandom);
    cfg(1, $urandom);
    cfg(2, 32'h0);
    seq = 100;
    for (int c = 0; c < 400; c++) begin
      bus.mem_gnt_i      = ($urandom_range(0, 3) != 0);
      bus.mon_valid_i    = $urandom_range(0, 1) == 1;
      bus.mon_svc_i      = 2'($urandom_range(0, 3));
      bus.mon_producer_i = 16'(seq);
      bus.mon_payload_i  = $urandom;
      seq++;
      step();
    end
    bus.mon_valid_i = 1'b0;
    bus.mem_gnt_i   = 1'b1;
    wait_idle(50);
    step();
    chk("rnd_left", 32'(exp_q.size()), 0);
    chk("rnd_drop", 32'(bus.drop_cnt_o), 32'(drop_m));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmni_brlite_mon_writer.md
# dmni_brlite_mon_writer

Parametrised BrLite monitor-sample writer for the DMNI: accepts decoded monitor packets (service, producer, payload) from the BrLite receive path, buffers them, and writes each payload into the per-service monitoring table in local memory. It generalises the fixed QoS/power monitor pointers to `NSVC` services with a configurable buffer depth, per-service disable, drop accounting and optional in-buffer coalescing. It sits between the BrLite monitor output and the DMNI memory write port; the MMR decoder drives its pointer and clear inputs.

## Interface
- `NSVC`, 2, number of monitor services; each has one table pointer register.
- `FIFO_DEPTH`, 4, sample buffer entries; power of two, ≥ 2.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `mon_valid_i` in 1: sample valid.
- `mon_ready_o` out 1: sample accepted when valid && ready.
- `mon_svc_i` in $clog2(NSVC): service index.
- `mon_producer_i` in 16: producer ID (table index).
- `mon_payload_i` in 32: sample payload.
- `cfg_we_i` in 1: write pointer register `cfg_svc_i`.
- `cfg_svc_i` in $clog2(NSVC): pointer index.
- `cfg_ptr_i` in 32: table base address; 0 disables the service.
- `clear_i` in 1: single-cycle pulse; flush buffer, clear drop counter.
- `mem_req_o` out 1: memory write request.
- `mem_gnt_i` in 1: grant; transfer completes on req && gnt.
- `mem_addr_o` out 32: byte address.
- `mem_data_o` out 32: write data.
- `drop_cnt_o` out 16: discarded-sample counter.
- `busy_o` out 1: buffer non-empty or request outstanding.

## Operation
- Reset: all pointers 0, buffer empty, FSM `IDLE`, `mem_req_o`=0, `mem_addr_o`=0, `mem_data_o`=0, `drop_cnt_o`=0, `busy_o`=0, `mon_ready_o`=0 while `rst_i` high.
- `mon_ready_o` = !full (plus coalesce hit, see Configuration). Full buffer stalls upstream; no drop on full.
- Accepted sample with `mon_svc_i` ≥ NSVC: discarded, not buffered, `drop_cnt_o`+1 (saturates 0xFFFF).
- FSM `IDLE`: if buffer non-empty, pop head, go `REQ`. At pop, if pointer[svc]==0: discard, `drop_cnt_o`+1, stay `IDLE`; else register `mem_addr_o` = pointer[svc] + {producer,2'b00} (32-bit, wraps modulo 2^32) and `mem_data_o` = payload.
- `REQ`: `mem_req_o`=1; addr/data stable until grant. On grant: if buffer non-empty pop next (same pointer check) and stay `REQ` with new addr/data; else `IDLE`. Discarded pop in `REQ`-after-grant goes to `IDLE`.
- `clear_i`: empties buffer, zeroes counter. In-flight `REQ` is not aborted; it completes its handshake. Sample accepted in the clear cycle is discarded, not counted. Drop increment in same cycle as clear: clear wins.
- `cfg_we_i`: pointer updates at clock edge; a pop in the same cycle uses the old value.
- Simultaneous accept and pop on a full buffer: `mon_ready_o` stays low (ready is from full only).

## Timing
- Accept in cycle N into empty buffer, FSM `IDLE`: pop in N+1, `mem_req_o` high in N+2.
- Back-to-back: one write per cycle while `mem_gnt_i` held high and buffer non-empty.
- `mem_req_o` drops the cycle after the last grant.
- `busy_o` registered-equivalent of (count≠0 || state==`REQ`); updates the cycle after the causing edge.
- Counter visible on `drop_cnt_o` the cycle after the drop event.

## Configuration
- `DMNI_MON_COALESCE_EN` defined: an accepted sample whose (svc, producer) matches a buffered entry overwrites that entry's payload in place (no new entry, order unchanged); `mon_ready_o` = !full || match, so a full buffer still accepts matching samples. Entry already popped into the output registers is not matched.
- Not defined: every valid sample occupies a new entry; `mon_ready_o` = !full.

## Test plan
- NSVC=2, ptr[1]=0x1000; sample svc=1, prod=3, payload=0xCAFE, gnt tied 1 -> `mem_req_o` at N+2, addr 0x100C, data 0xCAFE, single cycle.
- ptr[0]=0; sample svc=0 -> no memory request, `drop_cnt_o`=1; ptr=0xFFFFFFFC, prod=1 -> addr 0x00000000 (wrap).
- gnt held 0, 5 samples with FIFO_DEPTH=4 (distinct producers) -> 1 in output regs, 4 buffered, `mon_ready_o`=0; release gnt -> 5 writes in order on consecutive cycles.
- `clear_i` during `REQ` with 3 buffered -> pending write completes, remaining 3 never issued, `drop_cnt_o`=0, `busy_o`=0 after.
- With `DMNI_MON_COALESCE_EN`, gnt=0, full buffer, sample matching entry 2 with payload 0x55 -> accepted, entry 2 written as 0x55, total writes = 5 not 6; without macro -> stalled.
- `cfg_we_i` to ptr[1]=0x2000 in same cycle as pop of svc=1 (old 0x1000) -> write uses 0x1000 base; next sample uses 0x2000.
